serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor_full_subtractor_cell.sv | 17 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : FSM encoding (IDLE=0, SHIFT=1, FINISH=2)
//   DEF_WIDTH : default operand/result width
package serial_subtractor_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake + operand/result bundle for serial_subtractor.
//   master : drives START/A/B/BIN, observes BUSY/DONE/DIFF/BOUT(/OVF)
//   slave  : the subtractor side
// Optional macro SERIAL_SUB_OVF_EN adds the OVF signed-overflow flag.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] DIFF;
  logic             BOUT;
`ifdef SERIAL_SUB_OVF_EN
  logic             OVF;

  modport master (output START, A, B, BIN, input BUSY, DONE, DIFF, BOUT, OVF);
  modport slave  (input START, A, B, BIN, output BUSY, DONE, DIFF, BOUT, OVF);
`else
  modport master (output START, A, B, BIN, input BUSY, DONE, DIFF, BOUT);
  modport slave  (input START, A, B, BIN, output BUSY, DONE, DIFF, BOUT);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// Combinational one-bit full subtractor: computes a - b - bin.
//   i_a, i_b, i_bin : minuend bit, subtrahend bit, borrow-in
//   o_d, o_bout     : difference bit, borrow-out
module full_subtractor_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_d    = w_axb ^ i_bin;
  // borrow when b > a, or when a == b and a borrow is pending
  assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, A - B - BIN, LSB first, one bit per clock.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : serial_subtractor_if.slave (START/A/B/BIN in, BUSY/DONE/DIFF/BOUT out)
// Optional macro SERIAL_SUB_OVF_EN adds the registered OVF output.
// Latency is WIDTH+1 cycles from the accepting edge to DONE; a new START is
// accepted in IDLE or in the DONE (FINISH) cycle, ignored while shifting.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input  logic CLK,
  input  logic RST,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic             r_bor, r_bout, r_busy, r_done;
  logic             w_d, w_bor, w_accept, w_last;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_amsb, r_bmsb, r_ovf;
`endif

  full_subtractor_cell u_cell (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_bin (r_bor),
    .o_d   (w_d),
    .o_bout(w_bor)
  );

  assign w_accept = ((r_state == IDLE) || (r_state == FINISH)) && bus.START;
  // all WIDTH bits have been shifted; the following SHIFT cycle publishes them
  assign w_last   = (r_cnt == CW'(WIDTH));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, FINISH: w_next = bus.START ? SHIFT : IDLE;
      SHIFT:        if (w_last) w_next = FINISH;
      default:      w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_bor  <= 1'b0;
      r_bout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
`endif
    end else begin
      r_busy <= (r_state == SHIFT) && !w_last;
      r_done <= (r_state == SHIFT) && w_last;
      if (w_accept) begin
        r_a   <= bus.A;
        r_b   <= bus.B;
        r_bor <= bus.BIN;
        r_res <= '0;
        r_cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
        // operand MSBs are shifted out, so keep them for the overflow test
        r_amsb <= bus.A[WIDTH-1];
        r_bmsb <= bus.B[WIDTH-1];
`endif
      end else if (r_state == SHIFT) begin
        if (!w_last) begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bor <= w_bor;
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_diff <= r_res;
          r_bout <= r_bor;
`ifdef SERIAL_SUB_OVF_EN
          r_ovf  <= (r_amsb != r_bmsb) && (r_res[WIDTH-1] != r_amsb);
`endif
        end
      end
    end
  end

  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;
  assign bus.DIFF = r_diff;
  assign bus.BOUT = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.OVF  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// OVF checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_subtractor_if #(.WIDTH(8)) u_if ();

  serial_subtractor #(.WIDTH(8)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  // Launch one operation from a point just after a rising edge. Returns the
  // cycle index (edges after the accepting edge) at which DONE was seen, 0 on
  // timeout, and the number of BUSY-high cycles. Optionally pulses START with
  // other operands at cycle 'inj' to probe that mid-shift requests are ignored.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input int inj, input logic [7:0] ia, input logic [7:0] ib,
                       output int done_at, output int busy_n);
    u_if.START = 1'b1; u_if.A = a; u_if.B = b; u_if.BIN = bin;
    @(posedge clk); #1;
    u_if.START = 1'b0;
    done_at = 0; busy_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (u_if.BUSY) busy_n++;
      if (u_if.DONE) begin done_at = c; break; end
      if (c == inj) begin u_if.START = 1'b1; u_if.A = ia; u_if.B = ib; end
      else u_if.START = 1'b0;
    end
    u_if.START = 1'b0;
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (u_if.DONE) cnt++;
    end
  endtask

  task automatic test_reset();
    u_if.START = 1'b0; u_if.A = '0; u_if.B = '0; u_if.BIN = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (u_if.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", u_if.BUSY); end
    n_tests++; if (u_if.DONE !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", u_if.DONE); end
    n_tests++; if (u_if.DIFF !== 8'h00) begin n_fail++; $display("FAIL rst_diff got=%h exp=00", u_if.DIFF); end
    n_tests++; if (u_if.BOUT !== 1'b0) begin n_fail++; $display("FAIL rst_bout got=%b exp=0", u_if.BOUT); end
`ifdef SERIAL_SUB_OVF_EN
    n_tests++; if (u_if.OVF !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%b exp=0", u_if.OVF); end
`endif
  endtask

  task automatic test_basic();
    int d, bz;
    do_op(8'h05, 8'h03, 1'b0, -1, 8'h00, 8'h00, d, bz);
    n_tests++; if (d !== 9) begin n_fail++; $display("FAIL basic_latency got=%0d exp=9", d); end
    n_tests++; if (bz !== 8) begin n_fail++; $display("FAIL basic_busy got=%0d exp=8", bz); end
    n_tests++; if (u_if.DIFF !== 8'h02) begin n_fail++; $display("FAIL basic_diff got=%h exp=02", u_if.DIFF); end
    n_tests++; if (u_if.BOUT !== 1'b0) begin n_fail++; $display("FAIL basic_bout got=%b exp=0", u_if.BOUT); end
  endtask

  task automatic test_borrow();
    int d, bz;
    do_op(8'h03, 8'h05, 1'b0, -1, 8'h00, 8'h00, d, bz);
    n_tests++; if (u_if.DIFF !== 8'hFE) begin n_fail++; $display("FAIL neg_diff got=%h exp=fe", u_if.DIFF); end
    n_tests++; if (u_if.BOUT !== 1'b1) begin n_fail++; $display("FAIL neg_bout got=%b exp=1", u_if.BOUT); end
`ifdef SERIAL_SUB_OVF_EN
    n_tests++; if (u_if.OVF !== 1'b0) begin n_fail++; $display("FAIL neg_ovf got=%b exp=0", u_if.OVF); end
`endif
    do_op(8'h00, 8'h00, 1'b1, -1, 8'h00, 8'h00, d, bz);
    n_tests++; if (u_if.DIFF !== 8'hFF) begin n_fail++; $display("FAIL bin_diff got=%h exp=ff", u_if.DIFF); end
    n_tests++; if (u_if.BOUT !== 1'b1) begin n_fail++; $display("FAIL bin_bout got=%b exp=1", u_if.BOUT); end
  endtask

  task automatic test_overflow();
    int d, bz;
    do_op(8'h80, 8'h01, 1'b0, -1, 8'h00, 8'h00, d, bz);
    n_tests++; if (u_if.DIFF !== 8'h7F) begin n_fail++; $display("FAIL ovf1_diff got=%h exp=7f", u_if.DIFF); end
    n_tests++; if (u_if.BOUT !== 1'b0) begin n_fail++; $display("FAIL ovf1_bout got=%b exp=0", u_if.BOUT); end
`ifdef SERIAL_SUB_OVF_EN
    n_tests++; if (u_if.OVF !== 1'b1) begin n_fail++; $display("FAIL ovf1_ovf got=%b exp=1", u_if.OVF); end
`endif
    do_op(8'h7F, 8'hFF, 1'b0, -1, 8'h00, 8'h00, d, bz);
    n_tests++; if (u_if.DIFF !== 8'h80) begin n_fail++; $display("FAIL ovf2_diff got=%h exp=80", u_if.DIFF); end
    n_tests++; if (u_if.BOUT !== 1'b1) begin n_fail++; $display("FAIL ovf2_bout got=%b exp=1", u_if.BOUT); end
`ifdef SERIAL_SUB_OVF_EN
    n_tests++; if (u_if.OVF !== 1'b1) begin n_fail++; $display("FAIL ovf2_ovf got=%b exp=1", u_if.OVF); end
`endif
  endtask

  task automatic test_back_to_back();
    int d, bz, nd;
    // intruding START at cycle 3 of the shift must be dropped
    do_op(8'h20, 8'h01, 1'b0, 3, 8'h10, 8'h01, d, bz);
    n_tests++; if (d !== 9) begin n_fail++; $display("FAIL ign_latency got=%0d exp=9", d); end
    n_tests++; if (u_if.DIFF !== 8'h1F) begin n_fail++; $display("FAIL ign_diff got=%h exp=1f", u_if.DIFF); end
    // START issued in the DONE cycle
    do_op(8'h10, 8'h01, 1'b0, -1, 8'h00, 8'h00, d, bz);
    n_tests++; if (d !== 9) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=9", d); end
    n_tests++; if (u_if.DIFF !== 8'h0F) begin n_fail++; $display("FAIL b2b_diff got=%h exp=0f", u_if.DIFF); end
    count_dones(12, nd);
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL b2b_extra_done got=%0d exp=0", nd); end
    n_tests++; if (u_if.DIFF !== 8'h0F) begin n_fail++; $display("FAIL b2b_hold got=%h exp=0f", u_if.DIFF); end
  endtask

  task automatic test_abort();
    int d, bz, nd;
    u_if.START = 1'b1; u_if.A = 8'h55; u_if.B = 8'h11; u_if.BIN = 1'b0;
    @(posedge clk); #1;
    u_if.START = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // reset together with a fresh START: reset must win
    rst = 1'b1; u_if.START = 1'b1; u_if.A = 8'h33; u_if.B = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0; u_if.START = 1'b0;
    n_tests++; if (u_if.BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", u_if.BUSY); end
    n_tests++; if (u_if.DONE !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", u_if.DONE); end
    n_tests++; if (u_if.DIFF !== 8'h00) begin n_fail++; $display("FAIL abort_diff got=%h exp=00", u_if.DIFF); end
    n_tests++; if (u_if.BOUT !== 1'b0) begin n_fail++; $display("FAIL abort_bout got=%b exp=0", u_if.BOUT); end
    count_dones(15, nd);
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
    do_op(8'h09, 8'h04, 1'b0, -1, 8'h00, 8'h00, d, bz);
    n_tests++; if (d !== 9) begin n_fail++; $display("FAIL fresh_latency got=%0d exp=9", d); end
    n_tests++; if (u_if.DIFF !== 8'h05) begin n_fail++; $display("FAIL fresh_diff got=%h exp=05", u_if.DIFF); end
    n_tests++; if (u_if.BOUT !== 1'b0) begin n_fail++; $display("FAIL fresh_bout got=%b exp=0", u_if.BOUT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
